// File: rtl/clad_pkg.sv
// Shared constants and types for the two-level carry-lookahead adder.
package clad_pkg;

  localparam int BLOCK_W = 4;

  typedef struct packed {
    logic p;
    logic g;
  } pg_t;

endpackage

// File: rtl/cla_block4.sv
// Combinational 4-bit lookahead cell: internal carries plus block propagate/generate.
module cla_block4
  import clad_pkg::*;
(
  input  logic [BLOCK_W-1:0] p,
  input  logic [BLOCK_W-1:0] g,
  input  logic               ci,
  output logic [BLOCK_W-1:0] c,
  output logic               bp,
  output logic               bg
);

  // Each carry is a flat sum-of-products so no carry waits on another.
  always_comb begin
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    bp   = &p;
    bg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  end

endmodule

// File: rtl/clad.sv
// Registered WIDTH-bit adder built from 4-bit lookahead cells and a second lookahead level.
module clad
  import clad_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             pg,
  output logic             gg
);

  localparam int NB = WIDTH / BLOCK_W;

  pg_t  [WIDTH-1:0] bit_pg;
  logic [WIDTH-1:0] p_vec;
  logic [WIDTH-1:0] g_vec;
  logic [WIDTH-1:0] c_vec;
  logic [NB-1:0]    blk_p;
  logic [NB-1:0]    blk_g;
  logic [NB-1:0]    blk_ci;
  logic [WIDTH-1:0] sum_next;
  logic             cout_next;
  logic             pg_next;
  logic             gg_next;

  // Carry into block k, expanded so every product term is independent of the others.
  function automatic logic la_carry(input logic [NB-1:0] bp_in, input logic [NB-1:0] bg_in,
                                    input logic c0, input int k);
    logic c;
    logic t;
    c = 1'b0;
    for (int j = 0; j < k; j++) begin
      t = bg_in[j];
      for (int m = j + 1; m < k; m++) t = t & bp_in[m];
      c = c | t;
    end
    t = c0;
    for (int m = 0; m < k; m++) t = t & bp_in[m];
    return c | t;
  endfunction

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bit_pg[i].p = a[i] ^ b[i];
    assign bit_pg[i].g = a[i] & b[i];
    assign p_vec[i]    = bit_pg[i].p;
    assign g_vec[i]    = bit_pg[i].g;
  end

  for (genvar k = 0; k < NB; k++) begin : g_blk
    assign blk_ci[k] = la_carry(blk_p, blk_g, cin, k);

    cla_block4 u_cla (
      .p  (p_vec[k*BLOCK_W +: BLOCK_W]),
      .g  (g_vec[k*BLOCK_W +: BLOCK_W]),
      .ci (blk_ci[k]),
      .c  (c_vec[k*BLOCK_W +: BLOCK_W]),
      .bp (blk_p[k]),
      .bg (blk_g[k])
    );
  end

  assign sum_next  = p_vec ^ c_vec;
  assign cout_next = la_carry(blk_p, blk_g, cin, NB);
  assign gg_next   = la_carry(blk_p, blk_g, 1'b0, NB);
  assign pg_next   = &p_vec;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum  <= '0;
      cout <= 1'b0;
      pg   <= 1'b0;
      gg   <= 1'b0;
    end else begin
      sum  <= sum_next;
      cout <= cout_next;
      pg   <= pg_next;
      gg   <= gg_next;
    end
  end

endmodule

// File: tb/tb_clad.sv
// Scoreboard bench: 4-bit and 16-bit instances checked against plain a+b+cin arithmetic.
module tb_clad;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  a4, b4, sum4;
  logic        cin4, cout4, pg4, gg4;
  logic [15:0] a16, b16, sum16;
  logic        cin16, cout16, pg16, gg16;

  always #5 clk = ~clk;

  clad #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .cin(cin4),
    .sum(sum4), .cout(cout4), .pg(pg4), .gg(gg4)
  );

  clad #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .cin(cin16),
    .sum(sum16), .cout(cout16), .pg(pg16), .gg(gg16)
  );

  typedef struct {
    logic [16:0] res;
    logic        pg;
    logic        gg;
    string       tag;
  } exp_t;

  exp_t q4[$];
  exp_t q16[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic exp_t model(input int w, input logic [15:0] x, input logic [15:0] y,
                                 input logic c, input logic r, input string tag);
    exp_t        e;
    logic [15:0] mask;
    logic [16:0] xs, ys;
    mask  = (w == 16) ? 16'hFFFF : 16'h000F;
    xs    = {1'b0, x & mask};
    ys    = {1'b0, y & mask};
    e.tag = tag;
    if (!r) begin
      e.res = '0;
      e.pg  = 1'b0;
      e.gg  = 1'b0;
    end else begin
      e.res = xs + ys + 17'(c);
      e.gg  = ((xs + ys) >> w) != 17'd0;
      e.pg  = ((x ^ y) & mask) == mask;
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [16:0] res, input logic p, input logic g,
                       input exp_t e);
    n_cmp++;
    if (res !== e.res || p !== e.pg || g !== e.gg) begin
      n_bad++;
      $display("FAIL %s: got cout_sum=%h pg=%b gg=%b, expected cout_sum=%h pg=%b gg=%b",
               name, res, p, g, e.res, e.pg, e.gg);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] x4, input logic [3:0] y4, input logic c4,
                      input logic [15:0] x16, input logic [15:0] y16, input logic c16,
                      input string tag);
    @(negedge clk);
    rst_n = r;
    a4    = x4;
    b4    = y4;
    cin4  = c4;
    a16   = x16;
    b16   = y16;
    cin16 = c16;
    q4.push_back(model(4, {12'b0, x4}, {12'b0, y4}, c4, r, tag));
    q16.push_back(model(16, x16, y16, c16, r, tag));
  endtask

  // Monitor: outputs are valid every cycle; sample just after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q4.size() > 0) begin
        e = q4.pop_front();
        check({"w4 ", e.tag}, {12'b0, cout4, sum4}, pg4, gg4, e);
      end
      if (q16.size() > 0) begin
        e = q16.pop_front();
        check({"w16 ", e.tag}, {cout16, sum16}, pg16, gg16, e);
      end
    end
  end

  function automatic logic [15:0] rep4(input logic [3:0] x);
    return {4{x}};
  endfunction

  initial begin
    logic [8:0] v;
    step(1'b0, 4'hF, 4'hF, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1, "reset");
    step(1'b0, 4'hF, 4'hF, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1, "reset");
    step(1'b1, 4'b0001, 4'b1010, 1'b0, rep4(4'b0001), rep4(4'b1010), 1'b0, "add_1_a");
    step(1'b1, 4'b1111, 4'b1111, 1'b0, rep4(4'b1111), rep4(4'b1111), 1'b0, "ones_ones");
    step(1'b1, 4'b0101, 4'b1011, 1'b0, rep4(4'b0101), rep4(4'b1011), 1'b0, "add_5_b");
    step(1'b1, 4'b1111, 4'b0000, 1'b1, 16'hFFFF, 16'h0000, 1'b1, "full_propagate");
    step(1'b1, 4'b0110, 4'b1100, 1'b0, rep4(4'b0110), rep4(4'b1100), 1'b0, "add_6_c");
    step(1'b1, 4'b1111, 4'b1111, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1, "max_inputs");
    step(1'b1, 4'b0000, 4'b0000, 1'b0, 16'h0000, 16'h0000, 1'b0, "zero");
    step(1'b0, 4'b1001, 4'b0111, 1'b1, 16'h8001, 16'h7FFF, 1'b1, "mid_reset");
    step(1'b1, 4'b1001, 4'b0111, 1'b1, 16'h8001, 16'h7FFF, 1'b1, "after_reset");

    for (int i = 0; i < 512; i++) begin
      v = 9'(i);
      step(1'b1, v[3:0], v[7:4], v[8], 16'($urandom()), 16'($urandom()), 1'($urandom()),
           "exhaustive");
    end

    for (int i = 0; i < 10000; i++) begin
      step(($urandom_range(0, 99) != 0), 4'($urandom()), 4'($urandom()), 1'($urandom()),
           16'($urandom()), 16'($urandom()), 1'($urandom()), "random");
    end

    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (q4.size() != 0 || q16.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d/%0d pending results, expected 0/0", q4.size(), q16.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
